// File: rtl/dram_fifo_pkg.sv
// Shared widths and entry layout for the DRAM-controller request FIFOs.
package dram_fifo_pkg;

    localparam int unsigned DRAM_DATA_W = 16;
    localparam int unsigned DRAM_ADDR_W = 24;

    typedef struct packed {
        logic [DRAM_DATA_W-1:0] data;
        logic [DRAM_ADDR_W-1:0] addr;
        logic                   last;
    } fifo_entry_t;

endpackage

// File: rtl/sync_addr_fifo_if.sv
// AXI-Stream-style valid/ready channel carrying {tdata, taddr, tlast}.
interface sync_addr_fifo_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 24
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [ADDR_W-1:0] taddr;
    logic              tlast;

    modport master (output tvalid, tdata, taddr, tlast, input tready);
    modport slave  (input tvalid, tdata, taddr, tlast, output tready);
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers and occupancy for a FIFO of arbitrary DEPTH, with synchronous flush.
module fifo_ptr_ctrl #(
    parameter int unsigned DEPTH = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    // Explicit wrap so non-power-of-2 depths stay in range.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sync_addr_fifo.sv
// Single-clock {data, addr, last} FIFO between request arbiter and DDR command issuer.
// Define SYNC_ADDR_FIFO_STATS_EN to build the overflow_sticky / high_water statistics.
module sync_addr_fifo
    import dram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W           = DRAM_DATA_W,
    parameter int unsigned ADDR_W           = DRAM_ADDR_W,
    parameter int unsigned DEPTH            = 128,
    parameter int unsigned PROGFULL_DEPTH   = 12,
    parameter int unsigned PROGEMPTY_THRESH = 10
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       flush,
    sync_addr_fifo_if.slave            s_axis,
    output logic                       s_axis_prog_full,
    sync_addr_fifo_if.master           m_axis,
    output logic                       m_axis_prog_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_sticky,
    output logic [$clog2(DEPTH+1)-1:0] high_water
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } entry_t;

    if (PROGFULL_DEPTH >= DEPTH || PROGEMPTY_THRESH >= DEPTH) begin : g_bad_cfg
        $error("sync_addr_fifo: PROGFULL_DEPTH and PROGEMPTY_THRESH must be below DEPTH");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    entry_t        mem [DEPTH];
    entry_t        head;

    // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
    assign s_axis.tready = !full && !flush;
    assign m_axis.tvalid = !empty;
    assign push          = s_axis.tvalid && s_axis.tready;
    assign pop           = m_axis.tvalid && m_axis.tready;

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk    (clk),
        .rst_n  (aresetn),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: s_axis.tdata, addr: s_axis.taddr, last: s_axis.tlast};
    end

    assign head          = mem[rd_ptr];
    assign m_axis.tdata  = head.data;
    assign m_axis.taddr  = head.addr;
    assign m_axis.tlast  = head.last;

    assign s_axis_prog_full  = (count >= CW'(DEPTH - PROGFULL_DEPTH));
    assign m_axis_prog_empty = (count <= CW'(PROGEMPTY_THRESH));

`ifdef SYNC_ADDR_FIFO_STATS_EN
    logic          overflow_q;
    logic [CW-1:0] high_water_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_q   <= 1'b0;
            high_water_q <= '0;
        end else if (flush) begin
            overflow_q   <= 1'b0;
            high_water_q <= '0;
        end else begin
            if (s_axis.tvalid && full) overflow_q <= 1'b1;
            if (count > high_water_q)  high_water_q <= count;
        end
    end

    assign overflow_sticky = overflow_q;
    assign high_water      = high_water_q;
`else
    assign overflow_sticky = 1'b0;
    assign high_water      = '0;
`endif

endmodule

// File: tb/tb_sync_addr_fifo.sv
// Scoreboard bench for sync_addr_fifo: DEPTH=8 and DEPTH=6 instances share clock and reset.
module tb_sync_addr_fifo;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 24;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } sb_entry_t;

    logic clk;
    logic aresetn;
    logic flush8;
    logic flush6;

    sync_addr_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) s8 ();
    sync_addr_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) m8 ();
    sync_addr_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) s6 ();
    sync_addr_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) m6 ();

    logic       pf8, pe8, ovf8;
    logic [3:0] cnt8, hw8;
    logic       pf6, pe6, ovf6;
    logic [2:0] cnt6, hw6;

    sync_addr_fifo #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .PROGFULL_DEPTH(2), .PROGEMPTY_THRESH(2)) u_dut8 (
        .clk(clk), .aresetn(aresetn), .flush(flush8),
        .s_axis(s8), .s_axis_prog_full(pf8),
        .m_axis(m8), .m_axis_prog_empty(pe8),
        .count(cnt8), .overflow_sticky(ovf8), .high_water(hw8)
    );

    sync_addr_fifo #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(6), .PROGFULL_DEPTH(1), .PROGEMPTY_THRESH(1)) u_dut6 (
        .clk(clk), .aresetn(aresetn), .flush(flush6),
        .s_axis(s6), .s_axis_prog_full(pf6),
        .m_axis(m6), .m_axis_prog_empty(pe6),
        .count(cnt6), .overflow_sticky(ovf6), .high_water(hw6)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    sb_entry_t   sb8[$];
    sb_entry_t   sb6[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record accepted writes and compare accepted reads against the queue.
    always @(negedge clk) begin
        sb_entry_t e;
        if (aresetn) begin
            if (flush8) begin
                sb8.delete();
            end else begin
                if (s8.tvalid && s8.tready) sb8.push_back('{data: s8.tdata, addr: s8.taddr, last: s8.tlast});
                if (m8.tvalid && m8.tready) begin
                    if (sb8.size() == 0) begin
                        check("sb8_unexpected_pop", 64'(m8.tdata), 64'hDEAD);
                    end else begin
                        e = sb8.pop_front();
                        check("sb8_data", 64'(m8.tdata), 64'(e.data));
                        check("sb8_addr", 64'(m8.taddr), 64'(e.addr));
                        check("sb8_last", 64'(m8.tlast), 64'(e.last));
                    end
                end
            end
            if (flush6) begin
                sb6.delete();
            end else begin
                if (s6.tvalid && s6.tready) sb6.push_back('{data: s6.tdata, addr: s6.taddr, last: s6.tlast});
                if (m6.tvalid && m6.tready) begin
                    if (sb6.size() == 0) begin
                        check("sb6_unexpected_pop", 64'(m6.tdata), 64'hDEAD);
                    end else begin
                        e = sb6.pop_front();
                        check("sb6_data", 64'(m6.tdata), 64'(e.data));
                        check("sb6_addr", 64'(m6.taddr), 64'(e.addr));
                        check("sb6_last", 64'(m6.tlast), 64'(e.last));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic l);
        s8.tvalid = 1'b1;
        s8.tdata  = d;
        s8.taddr  = a;
        s8.tlast  = l;
        step();
        s8.tvalid = 1'b0;
    endtask

    task automatic drain8(input int n);
        m8.tready = 1'b1;
        repeat (n) step();
        m8.tready = 1'b0;
    endtask

    initial begin
        aresetn   = 1'b0;
        flush8    = 1'b0;
        flush6    = 1'b0;
        s8.tvalid = 1'b0; s8.tdata = '0; s8.taddr = '0; s8.tlast = 1'b0;
        m8.tready = 1'b0;
        s6.tvalid = 1'b0; s6.tdata = '0; s6.taddr = '0; s6.tlast = 1'b0;
        m6.tready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready",     64'(s8.tready), 64'd1);
        check("rst_tvalid",     64'(m8.tvalid), 64'd0);
        check("rst_count",      64'(cnt8),      64'd0);
        check("rst_prog_empty", 64'(pe8),       64'd1);
        check("rst_prog_full",  64'(pf8),       64'd0);
        check("rst_ovf",        64'(ovf8),      64'd0);
        check("rst_hw",         64'(hw8),       64'd0);
        check("rst_tready6",    64'(s6.tready), 64'd1);
        @(posedge clk); #1;
        aresetn = 1'b1;
        step();

        // Fill DEPTH=8, then drain in order
        for (int i = 0; i < 8; i++) push8(DW'((i + 1) * 17), AW'(i), (i == 3) || (i == 7));
        @(negedge clk);
        check("fill_count",      64'(cnt8),      64'd8);
        check("fill_tready",     64'(s8.tready), 64'd0);
        check("fill_prog_full",  64'(pf8),       64'd1);
        check("fill_prog_empty", 64'(pe8),       64'd0);
        step();
        drain8(8);
        @(negedge clk);
        check("drain_count",  64'(cnt8),       64'd0);
        check("drain_tvalid", 64'(m8.tvalid),  64'd0);
        check("drain_sb",     64'(sb8.size()), 64'd0);
        check("drain_pe",     64'(pe8),        64'd1);

        // Full with simultaneous push attempt and pop
        step();
        for (int i = 0; i < 8; i++) push8(DW'(16'h0200 + i), AW'(24'h100 + i), i[0]);
        s8.tvalid = 1'b1; s8.tdata = 16'h0099; s8.taddr = 24'h999; s8.tlast = 1'b0;
        m8.tready = 1'b1;
        step();
        s8.tvalid = 1'b0;
        m8.tready = 1'b0;
        @(negedge clk);
        check("fullpp_count",  64'(cnt8),      64'd7);
        check("fullpp_tready", 64'(s8.tready), 64'd1);
        step();
        drain8(7);
        @(negedge clk);
        check("fullpp_drain", 64'(cnt8), 64'd0);

        // DEPTH=6: steady push/pop pairs across pointer wrap
        step();
        s6.tvalid = 1'b1; s6.tdata = 16'h6000; s6.taddr = 24'h0; s6.tlast = 1'b0;
        step();
        m6.tready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            s6.tdata = DW'(16'h6000 + i);
            s6.taddr = AW'(i * 3);
            s6.tlast = (i % 5 == 0);
            @(negedge clk);
            check("wrap_count", 64'(cnt6), 64'd1);
            @(posedge clk); #1;
        end
        s6.tvalid = 1'b0;
        step();
        m6.tready = 1'b0;
        @(negedge clk);
        check("wrap_drained", 64'(cnt6),       64'd0);
        check("wrap_sb",      64'(sb6.size()), 64'd0);

        // Flush with 5 entries while a push of 0xAB is attempted
        step();
        for (int i = 0; i < 5; i++) push8(DW'(16'h0500 + i), AW'(i), 1'b0);
        flush8    = 1'b1;
        s8.tvalid = 1'b1; s8.tdata = 16'h00AB; s8.taddr = 24'hAB; s8.tlast = 1'b1;
        @(negedge clk);
        check("flush_tready", 64'(s8.tready), 64'd0);
        @(posedge clk); #1;
        flush8    = 1'b0;
        s8.tvalid = 1'b0;
        @(negedge clk);
        check("flush_count",  64'(cnt8),     64'd0);
        check("flush_tvalid", 64'(m8.tvalid), 64'd0);
        step();
        push8(16'h0077, 24'h77, 1'b1);
        drain8(2);
        @(negedge clk);
        check("post_flush_count", 64'(cnt8), 64'd0);

`ifdef SYNC_ADDR_FIFO_STATS_EN
        // Overflow and high-water statistics
        step();
        for (int i = 0; i < 9; i++) push8(DW'(16'h0900 + i), AW'(i), 1'b0);
        @(negedge clk);
        check("stats_ovf", 64'(ovf8), 64'd1);
        check("stats_hw",  64'(hw8),  64'd8);
        step();
        flush8 = 1'b1;
        step();
        flush8 = 1'b0;
        @(negedge clk);
        check("stats_ovf_flush", 64'(ovf8), 64'd0);
        check("stats_hw_flush",  64'(hw8),  64'd0);
        check("stats_cnt_flush", 64'(cnt8), 64'd0);
`else
        check("nostats_ovf", 64'(ovf8), 64'd0);
        check("nostats_hw",  64'(hw8),  64'd0);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
